// File: rtl/ula_pkg.sv
// Shared opcodes, ALU control word and FSM encodings for the 2-bit ALU slice sequencer.
package ula_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_NOTB  = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_INCB  = 3'b101;
  localparam logic [2:0] OP_NEGA  = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  // Field order matches the ALU control lines, MSB first: INVA ENA ENB F0 F1 CIN.
  typedef struct packed {
    logic inva;
    logic ena;
    logic enb;
    logic f0;
    logic f1;
    logic cin;
  } ctrl_t;

  localparam int CTRL_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_NEGA);
  endfunction

endpackage

// File: rtl/ula_op_decode.sv
// Combinational opcode decoder: opcode -> ALU control word plus arithmetic-op flag.
module ula_op_decode
  import ula_pkg::*;
(
  input  logic [2:0] op_i,
  output ctrl_t      ctrl_o,
  output logic       is_arith_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (op_i)
      OP_AND:   ctrl_o = 6'b011_000;
      OP_OR:    ctrl_o = 6'b011_010;
      OP_NOTB:  ctrl_o = 6'b011_100;
      OP_ADD:   ctrl_o = 6'b011_110;
      OP_SUB:   ctrl_o = 6'b111_111;
      OP_INCB:  ctrl_o = 6'b001_111;
      OP_NEGA:  ctrl_o = 6'b110_111;
      OP_PASSA: ctrl_o = 6'b010_010;
      default:  ctrl_o = '0;
    endcase
  end

  assign is_arith_o = op_is_arith(op_i);

endmodule

// File: rtl/ula_seq_ctrl.sv
// Sequences WIDTH-bit operations through one external 2-bit ALU slice, LSB slice first.
// Optional result flags (res_zero, res_ovf) are built when ULA_SEQ_FLAGS_EN is defined.
module ula_seq_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_cout,
`ifdef ULA_SEQ_FLAGS_EN
  output logic             res_zero,
  output logic             res_ovf,
`endif
  output logic [1:0]       alu_a,
  output logic [1:0]       alu_b,
  output logic             alu_inva,
  output logic             alu_ena,
  output logic             alu_enb,
  output logic             alu_f0,
  output logic             alu_f1,
  output logic             alu_cin,
  input  logic [1:0]       alu_out,
  input  logic             alu_cout,
  output state_e           dbg_state
);

  localparam int NS = WIDTH / 2;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  // Handshakes: a request is taken when start is high and the block is either idle or
  // handing its result over in the same cycle (res_valid && res_ready); a result leaves
  // on the edge where res_valid && res_ready, and it holds otherwise.

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, result_q;
  logic              carry_q, cout_q, arith_q;
  ctrl_t             ctrl_q, dec_ctrl;
  logic              dec_arith;
  logic              accept, last;
  logic [WIDTH-1:0]  result_nxt;

  ula_op_decode u_dec (
    .op_i       (op),
    .ctrl_o     (dec_ctrl),
    .is_arith_o (dec_arith)
  );

  assign accept = start && ((state_q == S_IDLE) || ((state_q == S_DONE) && res_ready));
  assign last   = (state_q == S_RUN) && (cnt_q == CW'(NS - 1));
  assign result_nxt = (result_q >> 2) | (WIDTH'(alu_out) << (WIDTH - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_RUN);
    res_valid = (state_q == S_DONE);
    alu_a     = '0;
    alu_b     = '0;
    alu_inva  = 1'b0;
    alu_ena   = 1'b0;
    alu_enb   = 1'b0;
    alu_f0    = 1'b0;
    alu_f1    = 1'b0;
    alu_cin   = 1'b0;
    if (state_q == S_RUN) begin
      alu_a    = a_q[1:0];
      alu_b    = b_q[1:0];
      alu_inva = ctrl_q.inva;
      alu_ena  = ctrl_q.ena;
      alu_enb  = ctrl_q.enb;
      alu_f0   = ctrl_q.f0;
      alu_f1   = ctrl_q.f1;
      alu_cin  = (cnt_q == '0) ? ctrl_q.cin : carry_q;
    end
  end

  // Operands shift right so the active slice always sits in bits [1:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      ctrl_q   <= '0;
      arith_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_q     <= a;
      b_q     <= b;
      carry_q <= 1'b0;
      ctrl_q  <= dec_ctrl;
      arith_q <= dec_arith;
    end else if (state_q == S_RUN) begin
      a_q      <= a_q >> 2;
      b_q      <= b_q >> 2;
      carry_q  <= alu_cout;
      result_q <= result_nxt;
      cnt_q    <= last ? '0 : cnt_q + CW'(1);
      if (last) cout_q <= arith_q & alu_cout;
    end
  end

  assign result    = result_q;
  assign res_cout  = cout_q;
  assign dbg_state = state_q;

`ifdef ULA_SEQ_FLAGS_EN
  logic zero_q, ovf_q, ea, eb;

  // On the last slice the operand registers hold the original MSBs in bit 1.
  assign ea = ctrl_q.ena ? (a_q[1] ^ ctrl_q.inva) : ctrl_q.inva;
  assign eb = ctrl_q.enb ? b_q[1] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (!accept && last) begin
      zero_q <= (result_nxt == '0);
      ovf_q  <= arith_q && (ea == eb) && (alu_out[1] != ea);
    end
  end

  assign res_zero = zero_q;
  assign res_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed bench for ula_seq_ctrl with a behavioural 2-bit ALU slice and a scoreboard queue.
module tb_ula_seq_ctrl;
  import ula_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         res_ready = 1'b1;
  logic         busy, res_valid, res_cout;
  logic [W-1:0] result;
  logic [1:0]   alu_a, alu_b, alu_out;
  logic         alu_inva, alu_ena, alu_enb, alu_f0, alu_f1, alu_cin, alu_cout;
  state_e       dbg_state;
  logic         res_zero, res_ovf;

  int n_vec = 0;
  int n_err = 0;

  // {ovf, zero, cout, result}
  logic [W+2:0] exp_q[$];

  ula_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .res_cout(res_cout),
`ifdef ULA_SEQ_FLAGS_EN
    .res_zero(res_zero), .res_ovf(res_ovf),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_inva(alu_inva), .alu_ena(alu_ena),
    .alu_enb(alu_enb), .alu_f0(alu_f0), .alu_f1(alu_f1), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .dbg_state(dbg_state)
  );

`ifndef ULA_SEQ_FLAGS_EN
  assign res_zero = 1'b0;
  assign res_ovf  = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural ULA2bit slice
  logic [1:0] ae, be;
  logic [2:0] sum;
  always_comb begin
    ae       = (alu_a & {2{alu_ena}}) ^ {2{alu_inva}};
    be       = alu_b & {2{alu_enb}};
    sum      = {1'b0, ae} + {1'b0, be} + {2'b00, alu_cin};
    alu_out  = 2'b00;
    alu_cout = 1'b0;
    case ({alu_f0, alu_f1})
      2'b00: alu_out = ae & be;
      2'b01: alu_out = ae | be;
      2'b10: alu_out = ~be;
      default: begin
        alu_out  = sum[1:0];
        alu_cout = sum[2];
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every completed result handshake.
  logic [W+2:0] e;
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(result), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e[W-1:0]));
        chk("res_cout", 32'(res_cout), 32'(e[W]));
`ifdef ULA_SEQ_FLAGS_EN
        chk("res_zero", 32'(res_zero), 32'(e[W+1]));
        chk("res_ovf", 32'(res_ovf), 32'(e[W+2]));
`endif
      end
    end
  end

  task automatic wait_valid(input string name);
    int lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (res_valid) break;
    end
    chk(name, 32'(lat), 32'd4);
  endtask

  // Issue one op from idle and let it complete with res_ready high.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] er, input logic ec, input logic ez, input logic ev);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = va; b = vb;
    exp_q.push_back({ev, ez, ec, er});
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_valid("latency");
    @(posedge clk); #1;
    chk("idle_after_handshake", 32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_cout"}, 32'(res_cout), 32'd0);
    chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_inva, alu_ena, alu_enb, alu_f0, alu_f1, alu_cin}), 32'd0);
    chk({tag, "_flags"}, 32'({res_zero, res_ovf}), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk); rst_n = 1'b1;

    //      op        a      b      result cout zero ovf
    run_op(OP_ADD,   8'h7F, 8'h01, 8'h80, 0, 0, 1);
    run_op(OP_ADD,   8'hFF, 8'h01, 8'h00, 1, 1, 0);
    run_op(OP_SUB,   8'h05, 8'h03, 8'hFE, 0, 0, 0);
    run_op(OP_SUB,   8'h03, 8'h05, 8'h02, 1, 0, 0);
    run_op(OP_SUB,   8'h80, 8'h00, 8'h80, 0, 0, 1);
    run_op(OP_NOTB,  8'h00, 8'hA5, 8'h5A, 0, 0, 0);
    run_op(OP_PASSA, 8'h3C, 8'hFF, 8'h3C, 0, 0, 0);
    run_op(OP_NEGA,  8'h01, 8'h77, 8'hFF, 0, 0, 0);
    run_op(OP_NEGA,  8'h00, 8'h00, 8'h00, 1, 1, 0);
    run_op(OP_AND,   8'hF0, 8'h3C, 8'h30, 0, 0, 0);
    run_op(OP_AND,   8'hF0, 8'h0F, 8'h00, 0, 1, 0);
    run_op(OP_OR,    8'hF0, 8'h0F, 8'hFF, 0, 0, 0);

    // Back-pressure: hold result while start is pulsed, then chain INCB on release.
    @(posedge clk); #1;
    res_ready = 1'b0;
    start = 1'b1; op = OP_ADD; a = 8'hFF; b = 8'h01;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'h00});
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid("bp_latency");
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      chk("bp_result_hold", 32'(result), 32'h00);
      chk("bp_cout_hold", 32'(res_cout), 32'd1);
      chk("bp_busy", 32'(busy), 32'd0);
      chk("bp_valid", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    op = OP_INCB; a = 8'h00; b = 8'h0F;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h10});
    @(posedge clk); #1;
    start = 1'b0;
    chk("chain_busy", 32'(busy), 32'd1);
    wait_valid("chain_latency");
    @(posedge clk); #1;

    // Reset during RUN after slice 2 of an ADD.
    start = 1'b1; op = OP_ADD; a = 8'h55; b = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run_op(OP_ADD, 8'h12, 8'h34, 8'h46, 0, 0, 0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
